// File: rtl/ann_mac_scheduler_if.sv
// ann_mac_scheduler_if
//   Groups the control and status signals between the ANN MAC scheduler and
//   the datapath or host around it.
//
//   Signals:
//     Start, Abort   host -> scheduler  pass request / cancel
//     wt_addr        weight-memory read address
//     in_sel, in_idx MAC operand source and index
//     mac_en,mac_clr MAC accumulate strobe / load-instead-of-add
//     act_we, act_layer, act_idx  activation capture strobe and target
//     Busy, Done     pass in progress / one-cycle completion pulse
//     state_dbg      current scheduler state encoding, for observation only
//
//   Handshake: Start is a one-cycle request that is taken only while Busy=0
//   (there is no queueing, a Start seen while Busy=1 is simply dropped).
//   Done is a one-cycle completion pulse. mac_en and act_we are fire-and-forget
//   strobes: the datapath must consume them in the cycle they are high, there
//   is no ready/backpressure path back to the scheduler.
interface ann_mac_scheduler_if;
    logic       Start;
    logic       Abort;
    logic [7:0] wt_addr;
    logic       in_sel;
    logic [4:0] in_idx;
    logic       mac_en;
    logic       mac_clr;
    logic       act_we;
    logic       act_layer;
    logic [2:0] act_idx;
    logic       Busy;
    logic       Done;
    logic [2:0] state_dbg;

    modport master (
        input  Start, Abort,
        output wt_addr, in_sel, in_idx, mac_en, mac_clr,
               act_we, act_layer, act_idx, Busy, Done, state_dbg
    );

    modport slave (
        output Start, Abort,
        input  wt_addr, in_sel, in_idx, mac_en, mac_clr,
               act_we, act_layer, act_idx, Busy, Done, state_dbg
    );
endinterface

// File: rtl/ann_mac_scheduler.sv
// ann_mac_scheduler
//   Sequences one forward pass of a two-layer fully connected network over a
//   single shared MAC. For each hidden neuron it streams N_IN weight/operand
//   pairs, waits out the one-cycle weight-memory latency, then strobes the
//   activation capture; the output layer does the same with N_HID operands
//   taken from the hidden-result register.
//
//   Ports:
//     Clock  rising-edge clock
//     Rst    synchronous active-high reset
//     bus    ann_mac_scheduler_if.master (Start/Abort in, schedule out)
module ann_mac_scheduler #(
    parameter int N_IN  = 30,
    parameter int N_HID = 5,
    parameter int N_OUT = 3
) (
    input  logic                       Clock,
    input  logic                       Rst,
    ann_mac_scheduler_if.master        bus
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        HID_ISSUE = 3'd1,
        HID_DRAIN = 3'd2,
        HID_ACT   = 3'd3,
        OUT_ISSUE = 3'd4,
        OUT_DRAIN = 3'd5,
        OUT_ACT   = 3'd6,
        FIN       = 3'd7
    } state_t;

    localparam logic [4:0] HID_LAST_I = 5'(N_IN - 1);
    localparam logic [4:0] OUT_LAST_I = 5'(N_HID - 1);
    localparam logic [2:0] HID_LAST_J = 3'(N_HID - 1);
    localparam logic [2:0] OUT_LAST_J = 3'(N_OUT - 1);

    state_t     state_q, state_d;
    logic [4:0] i_q, i_d;        // operand counter
    logic [2:0] j_q, j_d;        // neuron counter (hidden j, then output k)
    logic [7:0] addr_q, addr_d;  // running weight address

    logic       issuing;         // an operand is being issued this cycle
    logic       issue_sel;       // operand source for the current issue
    logic       mac_en_q;
    logic       mac_clr_q;

    // Last issued operand, shown on the bus outside the ISSUE states.
    logic [7:0] wt_addr_hold_q;
    logic [4:0] in_idx_hold_q;
    logic       in_sel_hold_q;

    // Weights are laid out hidden-neuron-major then output-neuron-major and
    // the schedule visits them in exactly that order, so a single running
    // address replaces the j*N_IN+i and N_HID*N_IN+k*N_HID+i products.
    always_ff @(posedge Clock) begin
        if (Rst) begin
            state_q        <= IDLE;
            i_q            <= '0;
            j_q            <= '0;
            addr_q         <= '0;
            mac_en_q       <= 1'b0;
            mac_clr_q      <= 1'b0;
            wt_addr_hold_q <= '0;
            in_idx_hold_q  <= '0;
            in_sel_hold_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            i_q       <= i_d;
            j_q       <= j_d;
            addr_q    <= addr_d;
            // Read data arrives one cycle after the address.
            mac_en_q  <= issuing && !bus.Abort;
            mac_clr_q <= issuing && !bus.Abort && (i_q == '0);
            if (issuing) begin
                wt_addr_hold_q <= addr_q;
                in_idx_hold_q  <= i_q;
                in_sel_hold_q  <= issue_sel;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        j_d       = j_q;
        addr_d    = addr_q;
        issuing   = 1'b0;
        issue_sel = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.Start && !bus.Abort) begin
                    state_d = HID_ISSUE;
                    i_d     = '0;
                    j_d     = '0;
                    addr_d  = '0;
                end
            end
            HID_ISSUE: begin
                issuing = 1'b1;
                addr_d  = addr_q + 8'd1;
                if (i_q == HID_LAST_I) begin
                    state_d = HID_DRAIN;
                end else begin
                    i_d = i_q + 5'd1;
                end
            end
            HID_DRAIN: state_d = HID_ACT;
            HID_ACT: begin
                i_d = '0;
                if (j_q == HID_LAST_J) begin
                    j_d     = '0;
                    state_d = OUT_ISSUE;
                end else begin
                    j_d     = j_q + 3'd1;
                    state_d = HID_ISSUE;
                end
            end
            OUT_ISSUE: begin
                issuing   = 1'b1;
                issue_sel = 1'b1;
                addr_d    = addr_q + 8'd1;
                if (i_q == OUT_LAST_I) begin
                    state_d = OUT_DRAIN;
                end else begin
                    i_d = i_q + 5'd1;
                end
            end
            OUT_DRAIN: state_d = OUT_ACT;
            OUT_ACT: begin
                i_d = '0;
                if (j_q == OUT_LAST_J) begin
                    j_d     = '0;
                    state_d = FIN;
                end else begin
                    j_d     = j_q + 3'd1;
                    state_d = OUT_ISSUE;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Abort overrides whatever the pass would have done next.
        if (bus.Abort && (state_q != IDLE)) begin
            state_d = IDLE;
            i_d     = '0;
            j_d     = '0;
            addr_d  = '0;
        end
    end

    logic in_act;
    assign in_act = (state_q == HID_ACT) || (state_q == OUT_ACT);

    assign bus.wt_addr   = issuing ? addr_q    : wt_addr_hold_q;
    assign bus.in_idx    = issuing ? i_q       : in_idx_hold_q;
    assign bus.in_sel    = issuing ? issue_sel : in_sel_hold_q;

    // The abort cycle itself produces no strobes.
    assign bus.mac_en    = mac_en_q  && !bus.Abort;
    assign bus.mac_clr   = mac_clr_q && !bus.Abort;
    assign bus.act_we    = in_act && !bus.Abort;
    assign bus.act_layer = (state_q == OUT_ACT);
    assign bus.act_idx   = in_act ? j_q : 3'd0;
    assign bus.Busy      = (state_q != IDLE);
    assign bus.Done      = (state_q == FIN) && !bus.Abort;
    assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_ann_mac_scheduler.sv
module tb_ann_mac_scheduler;
    localparam int N_IN     = 30;
    localparam int N_HID    = 5;
    localparam int N_OUT    = 3;
    localparam int PASS_LEN = 1 + N_HID * (N_IN + 2) + N_OUT * (N_HID + 2);
    localparam int W        = 40;
    localparam int MAX_CYC  = 16384;

    logic Clock = 1'b0;
    logic Rst;
    always #5 Clock = ~Clock;

    ann_mac_scheduler_if bus ();

    ann_mac_scheduler #(.N_IN(N_IN), .N_HID(N_HID), .N_OUT(N_OUT)) dut (
        .Clock (Clock),
        .Rst   (Rst),
        .bus   (bus.master)
    );

    int cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    logic [W-1:0] exp_q[$];
    bit           exp_busy [0:MAX_CYC-1];

    // Pass-level reference model: a pass is either running or not, and when
    // one is accepted its whole event trace is written out from the layer
    // arithmetic.
    bit m_active = 1'b0;
    int m_end    = 0;

    int mac_cnt, act_h_cnt, act_o_cnt, done_cnt;
    bit mon_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    endtask

    // kind: 1 = MAC, 2 = activation capture, 3 = done
    function automatic logic [W-1:0] pack(input int kind, input int c, input int flag,
                                          input int addr, input int sel, input int idx,
                                          input int aidx);
        return {kind[1:0], c[13:0], flag[0], addr[7:0], sel[0], idx[4:0], aidx[2:0], 6'd0};
    endfunction

    function automatic int ev_cyc(input logic [W-1:0] ev);
        return int'(ev[37:24]);
    endfunction

    task automatic push_pass(input int s);
        int base;
        int obase;
        for (int j = 0; j < N_HID; j++) begin
            base = s + 1 + j * (N_IN + 2);
            for (int i = 0; i < N_IN; i++)
                exp_q.push_back(pack(1, base + i + 1, (i == 0) ? 1 : 0, j * N_IN + i, 0, i, 0));
            exp_q.push_back(pack(2, base + N_IN + 1, 0, j * N_IN + N_IN - 1, 0, N_IN - 1, j));
        end
        obase = s + 1 + N_HID * (N_IN + 2);
        for (int k = 0; k < N_OUT; k++) begin
            base = obase + k * (N_HID + 2);
            for (int i = 0; i < N_HID; i++)
                exp_q.push_back(pack(1, base + i + 1, (i == 0) ? 1 : 0,
                                     N_HID * N_IN + k * N_HID + i, 1, i, 0));
            exp_q.push_back(pack(2, base + N_HID + 1, 1, N_HID * N_IN + k * N_HID + N_HID - 1,
                                 1, N_HID - 1, k));
        end
        exp_q.push_back(pack(3, obase + N_OUT * (N_HID + 2), 0, 0, 0, 0, 0));
    endtask

    task automatic purge_from(input int c);
        while (exp_q.size() > 0 && ev_cyc(exp_q[exp_q.size() - 1]) >= c)
            void'(exp_q.pop_back());
    endtask

    task automatic model_step(input int c, input bit st, input bit ab, input bit rs);
        exp_busy[c] = m_active;
        if (rs) begin
            purge_from(c + 1);
            m_active = 1'b0;
        end else if (m_active && ab) begin
            purge_from(c);
            m_active = 1'b0;
        end else if (m_active && c == m_end) begin
            m_active = 1'b0;
        end else if (!m_active && st && !ab) begin
            m_active = 1'b1;
            m_end    = c + PASS_LEN;
            push_pass(c);
        end
    endtask

    task automatic drive(input bit st, input bit ab, input bit rs);
        @(posedge Clock);
        #1;
        bus.Start = st;
        bus.Abort = ab;
        Rst       = rs;
        model_step(cyc, st, ab, rs);
    endtask

    task automatic idle(input int n);
        for (int t = 0; t < n; t++) drive(1'b0, 1'b0, 1'b0);
    endtask

    task automatic clear_counts();
        mac_cnt = 0; act_h_cnt = 0; act_o_cnt = 0; done_cnt = 0;
    endtask

    task automatic check_zero(input string name);
        check(name, 64'({bus.wt_addr, bus.in_sel, bus.in_idx, bus.mac_en, bus.mac_clr,
                         bus.act_we, bus.act_layer, bus.act_idx, bus.Busy, bus.Done}), 64'd0);
    endtask

    // Monitor: compares every presented strobe against the scoreboard.
    logic [7:0]   prev_addr;
    logic         prev_sel;
    logic [4:0]   prev_idx;
    logic [W-1:0] obs, front;
    int           nstrobe;

    always @(negedge Clock) begin
        if (mon_en) begin
            check("busy", 64'(bus.Busy), 64'(exp_busy[cyc]));
            while (exp_q.size() > 0 && ev_cyc(exp_q[0]) < cyc) begin
                front = exp_q.pop_front();
                check("missed_event", 64'd0, 64'(front));
            end
            nstrobe = int'(bus.mac_en) + int'(bus.act_we) + int'(bus.Done);
            if (nstrobe > 1) begin
                check("strobe_exclusive", 64'(nstrobe), 64'd1);
            end else if (nstrobe == 1) begin
                if (bus.mac_en)
                    obs = pack(1, cyc, int'(bus.mac_clr), int'(prev_addr), int'(prev_sel),
                               int'(prev_idx), 0);
                else if (bus.act_we)
                    obs = pack(2, cyc, int'(bus.act_layer), int'(bus.wt_addr), int'(bus.in_sel),
                               int'(bus.in_idx), int'(bus.act_idx));
                else
                    obs = pack(3, cyc, 0, 0, 0, 0, 0);
                if (exp_q.size() == 0) begin
                    check("unexpected_event", 64'(obs), 64'd0);
                end else begin
                    front = exp_q.pop_front();
                    check("event", 64'(obs), 64'(front));
                end
            end
            if (bus.mac_en) mac_cnt++;
            if (bus.act_we && !bus.act_layer) act_h_cnt++;
            if (bus.act_we && bus.act_layer) act_o_cnt++;
            if (bus.Done) done_cnt++;
        end
        prev_addr = bus.wt_addr;
        prev_sel  = bus.in_sel;
        prev_idx  = bus.in_idx;
    end

    initial begin
        Rst       = 1'b1;
        bus.Start = 1'b0;
        bus.Abort = 1'b0;
        clear_counts();
        repeat (3) drive(1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0);
        mon_en = 1'b1;
        @(negedge Clock);
        check_zero("reset_outputs");

        // Basic pass with full address sweep.
        clear_counts();
        drive(1'b1, 1'b0, 1'b0);
        idle(190);
        check("basic_mac_count", 64'(mac_cnt), 64'(N_HID * N_IN + N_OUT * N_HID));
        check("basic_act_hidden", 64'(act_h_cnt), 64'(N_HID));
        check("basic_act_out", 64'(act_o_cnt), 64'(N_OUT));
        check("basic_done", 64'(done_cnt), 64'd1);

        // Abort at relative cycle 100, restart at 105.
        clear_counts();
        drive(1'b1, 1'b0, 1'b0);
        idle(99);
        drive(1'b0, 1'b1, 1'b0);
        idle(4);
        drive(1'b1, 1'b0, 1'b0);
        idle(190);
        check("abort_done", 64'(done_cnt), 64'd1);
        check("abort_act_hidden", 64'(act_h_cnt), 64'(3 + N_HID));

        // Start held high through relative cycles 0..190.
        clear_counts();
        for (int t = 0; t <= 190; t++) drive(1'b1, 1'b0, 1'b0);
        idle(200);
        check("held_start_done", 64'(done_cnt), 64'd2);

        // Reset mid-pass.
        clear_counts();
        drive(1'b1, 1'b0, 1'b0);
        idle(49);
        drive(1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0);
        @(negedge Clock);
        check_zero("rst_mid_pass_outputs");
        idle(200);
        check("rst_mid_pass_done", 64'(done_cnt), 64'd0);

        // Start together with Abort in IDLE.
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        @(negedge Clock);
        check("start_abort_idle_busy", 64'(bus.Busy), 64'd0);
        idle(5);

        // Random Start/Abort/Rst traffic.
        for (int t = 0; t < 3000; t++)
            drive(($urandom_range(0, 19) == 0), ($urandom_range(0, 299) == 0),
                  ($urandom_range(0, 999) == 0));
        idle(200);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/ann_mac_scheduler.md
ANN_MAC_SCHEDULER -- requirements
Module: ann_mac_scheduler

Interface
REQ-001 Parameters SHALL be:
- N_IN, default 30, input-vector length.
- N_HID, default 5, hidden neurons.
- N_OUT, default 3, output neurons.
REQ-002 Clock and reset SHALL be: there is one clock; reset is synchronous and active-high.
REQ-003 Ports SHALL be:
- Clock  in  1  rising-edge clock.
- Rst  in  1  synchronous active-high reset.
- Start  in  1  one-cycle request to run one forward pass.
- Abort  in  1  synchronous cancel of the running pass.
- wt_addr  out  8  weight-memory read address (hidden weights 0..149, output weights 150..164).
- in_sel  out  1  MAC operand source: 0 = input vector in1, 1 = hidden-result register out_hid.
- in_idx  out  5  operand index into the source selected by in_sel.
- mac_en  out  1  MAC accumulate strobe, aligned with weight-memory read data.
- mac_clr  out  1  with mac_en: load the product instead of adding it.
- act_we  out  1  activation-result capture strobe.
- act_layer  out  1  destination of act_we: 0 = out_hid, 1 = out_ann.
- act_idx  out  3  neuron index for act_we.
- Busy  out  1  high while a pass is in progress.
- Done  out  1  one-cycle pulse when a pass completes.

Function
REQ-004 The FSM SHALL have the states IDLE, HID_ISSUE, HID_DRAIN, HID_ACT, OUT_ISSUE, OUT_DRAIN, OUT_ACT and FIN.
REQ-005 IDLE SHALL go to HID_ISSUE on the next edge when Start=1 and Abort=0, with neuron counter j=0 and operand counter i=0.
REQ-006 In HID_ISSUE, each cycle SHALL drive in_sel=0, in_idx=i and wt_addr=j*N_IN+i, then increment i; after i=N_IN-1 the FSM SHALL go to HID_DRAIN.
REQ-007 mac_en SHALL be a one-cycle-delayed copy of the ISSUE-state "issuing" flag (one-cycle weight-memory read latency), so that it is high in the last DRAIN cycle; mac_clr SHALL be high with the mac_en of operand i=0 only.
REQ-008 HID_DRAIN SHALL last 1 cycle and go to HID_ACT.
REQ-009 HID_ACT SHALL last 1 cycle with act_we=1, act_layer=0 and act_idx=j.
  - If j<N_HID-1: increment j, clear i, go to HID_ISSUE.
  - Otherwise: clear j and i, go to OUT_ISSUE.
REQ-010 OUT_ISSUE, OUT_DRAIN and OUT_ACT SHALL mirror REQ-006 to REQ-009 with these differences:
  - operand count is N_HID, with in_sel=1;
  - wt_addr = N_HID*N_IN + k*N_HID + i for output neuron k;
  - act_layer=1;
  - after k=N_OUT-1 the FSM goes to FIN.
REQ-011 FIN SHALL last 1 cycle with Done=1 and then go to IDLE unconditionally; Start in FIN SHALL be ignored.
REQ-012 With default parameters, Start sampled high in cycle 0 SHALL give:
  - hidden layer in cycles 1..160 (32 cycles per neuron);
  - output layer in cycles 161..181 (7 cycles per neuron);
  - Done=1 in cycle 182.
REQ-013 Busy SHALL be 1 in every state except IDLE.
REQ-014 Start while Busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-015 Abort=1 in any non-IDLE state SHALL force IDLE on the next edge, clear all counters, deassert mac_en and mac_clr that cycle, and produce no Done.
REQ-016 Abort and Start both high in IDLE: Abort SHALL win and the FSM SHALL stay in IDLE.
REQ-017 mac_en, act_we and Done SHALL never be high in the same cycle; outside ISSUE states, wt_addr, in_idx and in_sel SHALL hold their last values.

Reset
REQ-018 When Rst=1 at a clock edge, the block SHALL enter IDLE and clear all counters and the mac_en pipeline register.
REQ-019 After reset, every output SHALL be 0.
REQ-020 Rst SHALL take priority over Start and Abort.
REQ-021 Rst asserted mid-pass SHALL discard the pass with no Done.

Verification
REQ-022 Basic pass: Start pulse in cycle 0.
  - Required: mac_en first high in cycle 2 with mac_clr=1; first act_we in cycle 32 with act_idx=0, act_layer=0; Done only in cycle 182; exactly 165 mac_en pulses, 5 act_we with act_layer=0 and 3 with act_layer=1.
REQ-023 Address sweep: wt_addr SHALL cover 0..164 exactly once each in ascending order, and in_idx SHALL wrap 29->0 during the hidden layer and 4->0 during the output layer.
REQ-024 Abort in cycle 100: Busy=0 from cycle 101; no act_we or Done after cycle 100; a new Start in cycle 105 yields Done in cycle 287.
REQ-025 Start held high through cycles 0..190: Done pulses in cycle 182, and a second pass starts in cycle 184 (Start seen again in IDLE in cycle 183).
REQ-026 Rst in cycle 50: all outputs 0 in cycle 51, no Done; Start together with Abort in IDLE: no state change.
